// File: rtl/fmc_seq_ctrl.sv
// FMC edge-select sequencer: N/M counting, reference/feedback injection, lock and timeout tracking.
// Optional feature macro: FMC_TIMEOUT_EN (WAIT_FB dwell timeout driving err).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | disabled or just reset; counters held at 0, ratio loadable
// S_RUN     | counting N pulses, injecting reference edges each N
// S_WAIT_FB | M frame complete; waiting for quiet inputs to inject feedback
module fmc_seq_ctrl #(
  parameter int NW          = 3,
  parameter int MW          = 2,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk_ext,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [NW-1:0] cfg_n,
  input  logic [MW-1:0] cfg_m,
  output logic          cfg_ready,
  input  logic          div_n,
  input  logic          div_m,
  input  logic          clk_out,
  output logic [NW-1:0] n_count,
  output logic [MW-1:0] m_count,
  output logic [1:0]    sel,
  output logic          frame_done,
  output logic          locked,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_FB} state_t;

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock
    $error("LOCK_FRAMES must be 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t        state, state_nxt;
  logic [2:0]    sync_q1, sync_s;
  logic          div_n_d;
  logic          div_n_s, div_m_s, clk_out_s;
  logic          n_pulse, fb_release, cfg_load, tmo_hit;
  logic [NW-1:0] n_reg, n_nxt;
  logic [MW-1:0] m_reg, m_nxt;
  logic [1:0]    sel_nxt;
  logic          fd_nxt;
  logic [3:0]    clean_cnt;

  // bit order: {clk_out, div_m, div_n}
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_s  <= '0;
      div_n_d <= 1'b0;
    end else begin
      sync_q1 <= {clk_out, div_m, div_n};
      sync_s  <= sync_q1;
      div_n_d <= sync_s[0];
    end
  end

  assign div_n_s    = sync_s[0];
  assign div_m_s    = sync_s[1];
  assign clk_out_s  = sync_s[2];
  assign n_pulse    = div_n_s & ~div_n_d;
  assign fb_release = ~clk_out_s & ~div_m_s & ~div_n_s;
  assign cfg_ready  = (state == S_IDLE) || (sel == 2'b01);
  assign cfg_load   = cfg_valid & cfg_ready;

`ifdef FMC_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT + 1);
  logic [DW-1:0] dwell;

  // down-counter reloads whenever we are outside WAIT_FB
  always_ff @(posedge clk_ext) begin
    if (rst || state != S_WAIT_FB) dwell <= DW'(TIMEOUT - 1);
    else if (dwell != '0)          dwell <= dwell - 1'b1;
  end

  assign tmo_hit = (state == S_WAIT_FB) && (dwell == '0) && !fb_release;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_ext) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_RUN;
        S_RUN:     if (m_count == m_reg) state_nxt = S_WAIT_FB;
        S_WAIT_FB: if (fb_release || tmo_hit) state_nxt = S_RUN;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_nxt = 2'b00;
    fd_nxt  = 1'b0;
    n_nxt   = n_count;
    m_nxt   = m_count;
    if (!en) begin
      n_nxt = '0;
      m_nxt = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (m_count != m_reg) begin
            // terminal check first: it outranks a coincident n_pulse
            if (n_count == n_reg && !div_n_s) begin
              sel_nxt = 2'b10;
              n_nxt   = '0;
              m_nxt   = m_count + 1'b1;
            end else if (n_pulse && n_count < n_reg) begin
              n_nxt = n_count + 1'b1;
            end
          end
        end
        S_WAIT_FB: begin
          if (fb_release) begin
            sel_nxt = 2'b01;
            fd_nxt  = 1'b1;
            n_nxt   = '0;
            m_nxt   = '0;
          end else if (tmo_hit) begin
            n_nxt = '0;
            m_nxt = '0;
          end
        end
        default: ;
      endcase
    end
    if (cfg_load) begin
      n_nxt = '0;
      m_nxt = '0;
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      n_count    <= '0;
      m_count    <= '0;
      sel        <= 2'b00;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      n_reg      <= NW'(1);
      m_reg      <= MW'(1);
      clean_cnt  <= '0;
    end else begin
      n_count    <= n_nxt;
      m_count    <= m_nxt;
      sel        <= sel_nxt;
      frame_done <= fd_nxt;
      if (cfg_load) begin
        n_reg <= (cfg_n == '0) ? NW'(1) : cfg_n;
        m_reg <= (cfg_m == '0) ? MW'(1) : cfg_m;
      end
      if (!en || cfg_load || tmo_hit)
        clean_cnt <= '0;
      else if (fd_nxt && clean_cnt != 4'(LOCK_FRAMES))
        clean_cnt <= clean_cnt + 1'b1;
      if (!en || cfg_load || tmo_hit)
        locked <= 1'b0;
      else if (frame_done && clean_cnt == 4'(LOCK_FRAMES))
        locked <= 1'b1;
      if (tmo_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmc_seq_ctrl.sv
// Directed self-checking bench for fmc_seq_ctrl; injection sequence is logged per cycle as R/F tokens.
module tb_fmc_seq_ctrl;

  logic       clk_ext = 1'b0;
  logic       rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [2:0] cfg_n = '0;
  logic [1:0] cfg_m = '0;
  logic       div_n = 1'b0, div_m = 1'b0, clk_out = 1'b0;
  logic       cfg_ready, frame_done, locked, err;
  logic [2:0] n_count;
  logic [1:0] m_count, sel;

  fmc_seq_ctrl #(.NW(3), .MW(2), .LOCK_FRAMES(4), .TIMEOUT(64)) dut (
    .clk_ext(clk_ext), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_n(cfg_n),
    .cfg_m(cfg_m), .cfg_ready(cfg_ready), .div_n(div_n), .div_m(div_m),
    .clk_out(clk_out), .n_count(n_count), .m_count(m_count), .sel(sel),
    .frame_done(frame_done), .locked(locked), .err(err)
  );

  always #5 clk_ext = ~clk_ext;

  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0;
  bit    div_run = 0;
  string seq;
  int    sel11_all = 0, sel11, fd_bad, fd_cnt, fd4_cyc, lock_rise, last_r, last_ev;
  int    rr_n, rr_bad, fr_n, fr_bad, n_max;
  bit    locked_q = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    seq = ""; sel11 = 0; fd_bad = 0; fd_cnt = 0; fd4_cyc = -1; lock_rise = -1;
    last_r = -1; last_ev = 0; rr_n = 0; rr_bad = 0; fr_n = 0; fr_bad = 0; n_max = 0;
  endtask

  // one clock: sample 1 ns after the edge, log events, then drive div_n
  task automatic step();
    @(posedge clk_ext);
    #1;
    cyc++;
    if (sel == 2'b11) begin sel11++; sel11_all++; end
    if (frame_done !== (sel == 2'b01)) fd_bad++;
    if (sel == 2'b10) begin
      if (last_ev == 1) begin rr_n++; if (cyc - last_r != 24) rr_bad++; end
      seq = {seq, "R"}; last_ev = 1; last_r = cyc;
    end
    if (sel == 2'b01) begin
      if (last_ev == 1) begin fr_n++; if (cyc - last_r != 2) fr_bad++; end
      seq = {seq, "F"}; last_ev = 2;
    end
    if (frame_done) begin fd_cnt++; if (fd_cnt == 4) fd4_cyc = cyc; end
    if (locked && !locked_q) lock_rise = cyc;
    locked_q = locked;
    if (int'(n_count) > n_max) n_max = int'(n_count);
    if (div_run && (cyc % 4 == 0)) div_n = ~div_n;
  endtask

  task automatic wait_sel(input logic [1:0] want, input int budget, input string tag);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (sel == want) found = 1;
    end
    chk_eq({tag, "_seen"}, found, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_sel"}, sel, 0);
    chk_eq({tag, "_n_count"}, n_count, 0);
    chk_eq({tag, "_m_count"}, m_count, 0);
    chk_eq({tag, "_frame_done"}, frame_done, 0);
    chk_eq({tag, "_locked"}, locked, 0);
    chk_eq({tag, "_err"}, err, 0);
    chk_eq({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    int ready_low, ready_bad, nz_sel, fb_cnt, n_after_err;
    bit got_ready, err_seen;
    clear_log();

    repeat (3) step();
    chk_reset_vals("rst");

    // load N=3, M=2 while idle
    rst = 0; cfg_valid = 1; cfg_n = 3; cfg_m = 2;
    step();
    cfg_valid = 0;
    chk_eq("idle_cfg_ready", cfg_ready, 1);

    clear_log();
    en = 1; div_run = 1;
    repeat (240) step();
    chk_eq("n3m2_seq", (seq.len() >= 12) && (seq.substr(0, 11) == "RRFRRFRRFRRF"), 1);
    chk_eq("n3m2_sel11", sel11, 0);
    chk_eq("n3m2_fd_vs_sel01", fd_bad, 0);
    chk_eq("n3m2_rr_gaps_seen", rr_n >= 4, 1);
    chk_eq("n3m2_rr_gap_24", rr_bad, 0);
    chk_eq("n3m2_fb_after_ref", fr_bad, 0);
    chk_eq("n3m2_fb_gaps_seen", fr_n >= 4, 1);
    chk_eq("n3m2_n_max", n_max, 3);
    chk_eq("n3m2_frames", fd_cnt, 4);
    chk_eq("lock_after_4th_fd", lock_rise, fd4_cyc + 1);
    chk_eq("locked_high", locked, 1);

    en = 0;
    step();
    chk_eq("dis_locked", locked, 0);
    chk_eq("dis_n_count", n_count, 0);
    chk_eq("dis_m_count", m_count, 0);
    chk_eq("dis_sel", sel, 0);

    // zero ratios clamp to 1/1
    chk_eq("idle2_cfg_ready", cfg_ready, 1);
    cfg_valid = 1; cfg_n = 0; cfg_m = 0;
    step();
    cfg_valid = 0;
    clear_log();
    en = 1;
    repeat (64) step();
    chk_eq("clamp_seq", (seq.len() >= 6) && (seq.substr(0, 5) == "RFRFRF"), 1);
    chk_eq("clamp_n_max", n_max, 1);
    chk_eq("clamp_fd_vs_sel01", fd_bad, 0);

    // ratio offered mid-frame is held off until the feedback injection cycle
    wait_sel(2'b01, 40, "mid_fb0");
    step(); step();
    cfg_valid = 1; cfg_n = 5; cfg_m = 1;
    ready_low = 0; ready_bad = 0; got_ready = 0;
    for (int i = 0; i < 40 && !got_ready; i++) begin
      step();
      if (cfg_ready !== (sel == 2'b01)) ready_bad++;
      if (cfg_ready) got_ready = 1; else ready_low++;
    end
    chk_eq("mid_ready_seen", got_ready, 1);
    chk_eq("mid_ready_sel", sel, 2'b01);
    chk_eq("mid_ready_low_cycles", ready_low >= 1, 1);
    chk_eq("mid_ready_only_at_fb", ready_bad, 0);
    step();
    cfg_valid = 0;
    clear_log();
    wait_sel(2'b01, 120, "n5_fb");
    chk_eq("n5_n_max", n_max, 5);
    chk_eq("n5_seq", seq == "RF", 1);

    // clk_out held high: feedback injection blocked
    clk_out = 1;
    clear_log();
    wait_sel(2'b10, 100, "hold_ref");
    nz_sel = 0; fb_cnt = 0; err_seen = 0; n_after_err = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sel != 2'b00) nz_sel++;
      if (sel == 2'b01) fb_cnt++;
      if (err_seen && int'(n_count) > n_after_err) n_after_err = int'(n_count);
      if (err) err_seen = 1;
    end
`ifdef FMC_TIMEOUT_EN
    chk_eq("tmo_err", err, 1);
    chk_eq("tmo_locked", locked, 0);
    chk_eq("tmo_no_fb", fb_cnt, 0);
    chk_eq("tmo_run_resumed", n_after_err > 0, 1);
`else
    chk_eq("hold_sel_quiet", nz_sel, 0);
    chk_eq("hold_err", err, 0);
    chk_eq("hold_m_count", m_count, 1);
`endif
    clk_out = 0;
    wait_sel(2'b01, 120, "release_fb");

    // reset in the cycle after a reference injection
    wait_sel(2'b10, 80, "pre_rst_ref");
    step();
    rst = 1;
    step();
    chk_reset_vals("midrst");
    rst = 0;
    clear_log();
    wait_sel(2'b01, 60, "post_rst_fb");
    chk_eq("post_rst_seq", seq == "RF", 1);
    chk_eq("post_rst_n_max", n_max, 1);

    chk_eq("never_sel11", sel11_all, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
